ffm_telemetry_hub: RTL and testbench
====================================

Name: ffm_telemetry_hub

Overview:
Four-channel sensor poller and telemetry framer.
- Periodically pulses a request line to each of four UART sensors.
- Receives a 15-byte reply from each sensor at 5 Mbaud and stores it in per-channel buffers.
- Continuously serialises the buffers into a fixed frame on the Orb_serial output for the onboard telemetry (Orb) link.

Parameters:
- BAUD_DIV, 16: clk80 cycles per UART bit (80 MHz / 5 Mbaud).
- REQ_PERIOD, 80000: clk80 cycles between request pulses (1 ms).
- REQ_PULSE, 16: request pulse width in cycles.
- NBYTES, 15: reply length in bytes per channel.
- ORB_DIV, 25: clk80 cycles per Orb output bit.
- SYNC, 8'h7E: Orb frame marker byte.

Ports:
- clk80  in  1  system clock, 80 MHz.
- rst  in  1  synchronous active-high reset.
- UART1_RX, UART3_RX, UART4_RX, UART5_RX  in  1 each  sensor data lines, channels 0..3.
- UART1_dRX, UART3_dRX, UART4_dRX, UART5_dRX  out  1 each  request lines, channels 0..3.
- UART7_RX  in  1  MCX data line (MCX_EN only).
- UART7_dRX  out  1  MCX request line (MCX_EN only).
- Orb_serial  out  1  NRZ telemetry stream, MSB first.
- Interface: one clock, clk80; reset rst is synchronous and active-high. All logic is on clk80.
- RX inputs are asynchronous and pass through a 2-flop synchroniser.

Behaviour:
- Reset:
  - all dRX outputs = 0; Orb_serial = 0.
  - period counter = 0; buffers = 0.
  - byte counts = 0; status = 0.
  - Orb sequencer restarts at the SYNC byte.
- Request timing:
  - Period counter counts 0..REQ_PERIOD-1 and wraps.
  - All dRX are high while count < REQ_PULSE, so the first pulse starts the cycle after reset deasserts.
  - On the rising edge of each pulse, each channel clears its byte index and complete flag.
- UART receiver (one per channel): 8 data bits, LSB first, no parity.
  - IDLE: line low for BAUD_DIV/2 consecutive cycles confirms a start bit.
  - DATA: sample at +BAUD_DIV intervals, 8 samples.
  - After bit 7, wait BAUD_DIV/2 cycles, then return to IDLE.
  - The stop bit is not checked; back-to-back bytes with zero-length stop bits must be received.
  - A start confirmed within a bit period of the previous byte is legal.
- Buffer write: received byte is written to buf[ch][idx] and idx increments.
  - At idx = NBYTES-1, set complete = 1.
  - Bytes beyond NBYTES are dropped; idx saturates.
  - A request edge coinciding with a byte write: the clear wins and the byte is discarded.
- Status byte per channel: {complete, 3'b000, idx[3:0]}.
- Orb frame, repeating with no gaps: SYNC, then for ch = 0..3 the 15 buffer bytes followed by the status byte. Total 65 bytes = 520 bits.
  - Each bit is held ORB_DIV cycles.
  - Each byte is loaded into the shift register at its first bit; buffers are read live, with no snapshot.
  - Byte order and bit order are fixed.
- Reset mid-frame: output drops to 0 the next cycle and the frame restarts at SYNC after release.

Optional Feature:
- Macro MCX_EN.
- When defined:
  - Adds a fifth channel on UART7_RX / UART7_dRX with the same request timing.
  - Buffer holds 144 bytes.
  - The Orb frame appends 144 MCX bytes plus an MCX status byte {complete, idx[7:1]} after channel 3.
  - Frame length is 210 bytes.
- When undefined: UART7 ports are absent and the frame is 65 bytes.

Decomposition:
- Package ffm_pkg holds:
  - SYNC, default NBYTES, status-byte bit positions.
  - UART FSM state enum (IDLE, START, DATA, TAIL).
  - Orb sequencer state enum.
- One sub-module, ffm_uart_rx (synchroniser + 8N0 receiver, outputs data/valid), instantiated per channel.
- Buffers, request timer and Orb sequencer live in the top.

Test Plan:
- Reset held 10 cycles -> all dRX = 0, Orb_serial = 0; first SYNC bit appears ORB_DIV cycles after release; dRX pulse lasts exactly 16 cycles.
- After the request falls, drive 15 bytes on UART1_RX at 5 Mbaud with zero-length stop bits: 85,145,146,147,148,85,149,150,151,152,85,153,154,155,156 -> buf[0] matches and status[0] = 8'h8F.
- The same sequence on all four channels simultaneously -> all statuses 8'h8F; Orb frame reads 7E 55 91 92 93 ... 9C 8F, repeated four times.
- Only 7 bytes sent on UART4_RX -> status[2] = 8'h07; remaining bytes are left at their reset value of 0.
- 17 bytes sent -> last two dropped, status 8'h8F; the next request pulse clears the status to 8'h00.
- rst asserted mid-reply -> buffer and status read 0 after release; the next pulse gives a normal reception.

Source files
------------

// File: rtl/ffm_pkg.sv
// ffm_pkg: shared constants, FSM state types and status-byte helper for the telemetry hub
package ffm_pkg;
  localparam logic [7:0] SYNC = 8'h7E;
  localparam int NBYTES_DEF = 15;
  localparam int MCX_BYTES = 144;
  localparam int ST_DONE = 7;
  localparam int ST_IDX_HI = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, TAIL} uart_st_t;
  typedef enum logic [2:0] {ORB_SYNC, ORB_DATA, ORB_STAT, ORB_MCX, ORB_MCX_STAT} orb_st_t;
  function automatic logic [7:0] status_byte(input logic done, input logic [3:0] idx);
    status_byte = '0;
    status_byte[ST_DONE] = done;
    status_byte[ST_IDX_HI:0] = idx;
  endfunction
endpackage

// File: rtl/ffm_uart_rx.sv
// ffm_uart_rx: 2-flop synchroniser plus 8N0 UART receiver (LSB first, stop bit not required)
// Ports: clk80, rst (sync, active-high), rx (async line), data (received byte), valid (1-cycle strobe)
module ffm_uart_rx import ffm_pkg::*; #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk80,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  logic [1:0] sync;
  uart_st_t st;
  logic [CW-1:0] cnt;
  logic [2:0] nbit;
  // TAIL ends exactly on the next bit boundary so back-to-back bytes without a stop bit stay aligned
  always_ff @(posedge clk80) begin
    if (rst) begin
      sync <= 2'b11;
      st <= IDLE;
      cnt <= '0;
      nbit <= '0;
      data <= '0;
      valid <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      valid <= 1'b0;
      case (st)
        IDLE: if (!sync[1]) begin
          st <= START;
          cnt <= CW'(1);
        end
        START: if (sync[1]) st <= IDLE;
        else if (cnt == HALF) begin
          st <= DATA;
          cnt <= '0;
          nbit <= '0;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          data <= {sync[1], data[7:1]};
          nbit <= nbit + 1'b1;
          if (nbit == 3'd7) begin
            st <= TAIL;
            valid <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        TAIL: if (cnt == HALF) begin
          st <= IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ffm_telemetry_hub.sv
// ffm_telemetry_hub: four-channel UART sensor poller with a continuous NRZ telemetry framer
// Ports: clk80, rst (sync, active-high); UARTn_RX sensor lines in; UARTn_dRX request pulses out;
//        Orb_serial frame stream out (SYNC, then per channel NBYTES buffer bytes + status, MSB first).
// Macro MCX_EN adds UART7_RX/UART7_dRX, a 144-byte MCX buffer and its bytes + status after channel 3.
module ffm_telemetry_hub import ffm_pkg::*; #(
  parameter int BAUD_DIV   = 16,
  parameter int REQ_PERIOD = 80000,
  parameter int REQ_PULSE  = 16,
  parameter int NBYTES     = NBYTES_DEF,
  parameter int ORB_DIV    = 25
) (
  input  logic clk80,
  input  logic rst,
  input  logic UART1_RX,
  input  logic UART3_RX,
  input  logic UART4_RX,
  input  logic UART5_RX,
  output logic UART1_dRX,
  output logic UART3_dRX,
  output logic UART4_dRX,
  output logic UART5_dRX,
`ifdef MCX_EN
  input  logic UART7_RX,
  output logic UART7_dRX,
`endif
  output logic Orb_serial
);
  localparam int PW = $clog2(REQ_PERIOD);
  localparam int DW = $clog2(ORB_DIV);
  logic [PW-1:0] per_cnt;
  logic req, req_rise;
  logic [3:0] rx_line, rx_valid, done;
  logic [7:0] rx_data [4];
  logic [7:0] rx_buf [4][NBYTES];
  logic [3:0] idx [4];
  logic [7:0] status [4];
  orb_st_t orb_st;
  logic [1:0] orb_ch;
  logic [7:0] orb_bidx, cur, mcx_byte, sr;
  logic [DW-1:0] div;
  logic [2:0] bitc;
  assign rx_line = {UART5_RX, UART4_RX, UART3_RX, UART1_RX};
  assign {UART5_dRX, UART4_dRX, UART3_dRX, UART1_dRX} = {4{req}};
  // count 0 is the cycle the request output rises, so it doubles as the rising-edge strobe
  assign req_rise = per_cnt == '0;
  always_ff @(posedge clk80) begin
    if (rst) begin
      per_cnt <= '0;
      req <= 1'b0;
    end else begin
      per_cnt <= per_cnt == PW'(REQ_PERIOD - 1) ? '0 : per_cnt + 1'b1;
      req <= per_cnt < PW'(REQ_PULSE);
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_rx
    ffm_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk80(clk80),
      .rst(rst),
      .rx(rx_line[i]),
      .data(rx_data[i]),
      .valid(rx_valid[i])
    );
  end
  // a request edge wins over a coincident byte, and idx saturates at NBYTES so extra bytes drop
  always_ff @(posedge clk80) begin
    if (rst) begin
      done <= '0;
      for (int c = 0; c < 4; c++) begin
        idx[c] <= '0;
        for (int j = 0; j < NBYTES; j++) rx_buf[c][j] <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (req_rise) begin
          idx[c] <= '0;
          done[c] <= 1'b0;
        end else if (rx_valid[c] && idx[c] != 4'(NBYTES)) begin
          rx_buf[c][idx[c]] <= rx_data[c];
          idx[c] <= idx[c] + 1'b1;
          if (idx[c] == 4'(NBYTES - 1)) done[c] <= 1'b1;
        end
      end
    end
  end
  always_comb
    for (int c = 0; c < 4; c++) status[c] = status_byte(done[c], idx[c]);
`ifdef MCX_EN
  logic [7:0] mcx_data, mcx_idx;
  logic [7:0] mcx_buf [MCX_BYTES];
  logic mcx_valid, mcx_done;
  assign UART7_dRX = req;
  ffm_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx7 (
    .clk80(clk80),
    .rst(rst),
    .rx(UART7_RX),
    .data(mcx_data),
    .valid(mcx_valid)
  );
  always_ff @(posedge clk80) begin
    if (rst) begin
      mcx_idx <= '0;
      mcx_done <= 1'b0;
      for (int j = 0; j < MCX_BYTES; j++) mcx_buf[j] <= '0;
    end else if (req_rise) begin
      mcx_idx <= '0;
      mcx_done <= 1'b0;
    end else if (mcx_valid && mcx_idx != 8'(MCX_BYTES)) begin
      mcx_buf[mcx_idx] <= mcx_data;
      mcx_idx <= mcx_idx + 1'b1;
      if (mcx_idx == 8'(MCX_BYTES - 1)) mcx_done <= 1'b1;
    end
  end
  assign mcx_byte = orb_st == ORB_MCX ? mcx_buf[orb_bidx] : {mcx_done, mcx_idx[7:1]};
`else
  assign mcx_byte = SYNC;
`endif
  always_comb
    cur = orb_st == ORB_SYNC ? SYNC :
          orb_st == ORB_DATA ? rx_buf[orb_ch][orb_bidx[3:0]] :
          orb_st == ORB_STAT ? status[orb_ch] : mcx_byte;
  // each byte is fetched live at its first bit; the sequencer then advances to the next byte slot
  always_ff @(posedge clk80) begin
    if (rst) begin
      Orb_serial <= 1'b0;
      div <= '0;
      bitc <= '0;
      sr <= '0;
      orb_st <= ORB_SYNC;
      orb_ch <= '0;
      orb_bidx <= '0;
    end else begin
      div <= div == DW'(ORB_DIV - 1) ? '0 : div + 1'b1;
      if (div == DW'(ORB_DIV - 1)) begin
        Orb_serial <= bitc == '0 ? cur[7] : sr[7];
        sr <= bitc == '0 ? {cur[6:0], 1'b0} : {sr[6:0], 1'b0};
        bitc <= bitc + 1'b1;
        if (bitc == 3'd7) begin
          case (orb_st)
            ORB_SYNC: begin
              orb_st <= ORB_DATA;
              orb_ch <= '0;
              orb_bidx <= '0;
            end
            ORB_DATA: begin
              orb_st <= orb_bidx == 8'(NBYTES - 1) ? ORB_STAT : ORB_DATA;
              orb_bidx <= orb_bidx + 1'b1;
            end
            ORB_STAT: begin
              orb_bidx <= '0;
              orb_ch <= orb_ch + 1'b1;
`ifdef MCX_EN
              orb_st <= orb_ch == 2'd3 ? ORB_MCX : ORB_DATA;
`else
              orb_st <= orb_ch == 2'd3 ? ORB_SYNC : ORB_DATA;
`endif
            end
            ORB_MCX: begin
              orb_st <= orb_bidx == 8'(MCX_BYTES - 1) ? ORB_MCX_STAT : ORB_MCX;
              orb_bidx <= orb_bidx + 1'b1;
            end
            default: orb_st <= ORB_SYNC;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ffm_telemetry_hub.sv
// tb_ffm_telemetry_hub: directed self-checking bench for the telemetry hub (default build, MCX_EN undefined)
`timescale 1ns/1ps
module tb_ffm_telemetry_hub;
  logic clk80 = 1'b0;
  logic rst = 1'b1;
  logic UART1_RX = 1'b1, UART3_RX = 1'b1, UART4_RX = 1'b1, UART5_RX = 1'b1;
  logic UART1_dRX, UART3_dRX, UART4_dRX, UART5_dRX, Orb_serial;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ns [4];
  logic [7:0] seq [17] = '{8'd85, 8'd145, 8'd146, 8'd147, 8'd148, 8'd85, 8'd149, 8'd150, 8'd151,
                           8'd152, 8'd85, 8'd153, 8'd154, 8'd155, 8'd156, 8'hAA, 8'hBB};

  ffm_telemetry_hub #(.REQ_PERIOD(30000)) dut (
    .clk80(clk80),
    .rst(rst),
    .UART1_RX(UART1_RX),
    .UART3_RX(UART3_RX),
    .UART4_RX(UART4_RX),
    .UART5_RX(UART5_RX),
    .UART1_dRX(UART1_dRX),
    .UART3_dRX(UART3_dRX),
    .UART4_dRX(UART4_dRX),
    .UART5_dRX(UART5_dRX),
    .Orb_serial(Orb_serial)
  );

  always #6 clk80 = ~clk80;
  always @(posedge clk80) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk80);
  endtask

  // Orb bit k is held from cycle ORB_DIV*(k+1) after release; sample mid-bit
  task automatic get_byte(input int k, output logic [7:0] v);
    v = '0;
    for (int b = 0; b < 8; b++) begin
      wait_cyc(25 * (8 * k + b + 1) + 12);
      v = {v[6:0], Orb_serial};
    end
  endtask

  // n0..n3 bytes from seq on channels 0..3 in parallel, 5 Mbaud, zero-length stop bits
  task automatic send(input int n0, input int n1, input int n2, input int n3);
    int n [4];
    int mx;
    logic [3:0] line;
    n = '{n0, n1, n2, n3};
    mx = 0;
    for (int c = 0; c < 4; c++) if (n[c] > mx) mx = n[c];
    for (int i = 0; i < mx; i++)
      for (int b = 0; b < 9; b++) begin
        for (int c = 0; c < 4; c++) line[c] = i >= n[c] ? 1'b1 : b == 0 ? 1'b0 : seq[i][b-1];
        {UART5_RX, UART4_RX, UART3_RX, UART1_RX} = line;
        repeat (16) @(negedge clk80);
      end
    {UART5_RX, UART4_RX, UART3_RX, UART1_RX} = 4'hF;
  endtask

  function automatic logic [7:0] exp_byte(input int j);
    int c, p, m;
    if (j == 0) return 8'h7E;
    c = (j - 1) / 16;
    p = (j - 1) % 16;
    m = ns[c] > 15 ? 15 : ns[c];
    if (p == 15) return {ns[c] >= 15, 3'b000, 4'(m)};
    return p < m ? seq[p] : 8'h00;
  endfunction

  initial begin
    logic [7:0] v;
    int n;
    repeat (10) @(negedge clk80);
    chk("drx_in_reset", {4'h0, UART5_dRX, UART4_dRX, UART3_dRX, UART1_dRX}, 8'h00);
    chk("orb_in_reset", {7'h0, Orb_serial}, 8'h00);
    rst = 1'b0;
    wait_cyc(1);
    chk("drx_pulse_start", {4'h0, UART5_dRX, UART4_dRX, UART3_dRX, UART1_dRX}, 8'h0F);
    wait_cyc(16);
    chk("drx_pulse_last", {4'h0, UART5_dRX, UART4_dRX, UART3_dRX, UART1_dRX}, 8'h0F);
    wait_cyc(17);
    chk("drx_pulse_end", {4'h0, UART5_dRX, UART4_dRX, UART3_dRX, UART1_dRX}, 8'h00);
    wait_cyc(49);
    chk("orb_sync_bit0", {7'h0, Orb_serial}, 8'h00);
    wait_cyc(50);
    chk("orb_sync_bit1", {7'h0, Orb_serial}, 8'h01);
    send(15, 15, 15, 15);
    ns = '{15, 15, 15, 15};
    for (int j = 0; j < 65; j++) begin
      get_byte(65 + j, v);
      chk($sformatf("all4_frame_byte_%0d", j), v, exp_byte(j));
    end
    wait_cyc(30020);
    send(5, 0, 0, 0);
    n = 0;
    while (Orb_serial !== 1'b1 && n < 1000) begin
      @(negedge clk80);
      n++;
    end
    chk("orb_high_before_rst", {7'h0, Orb_serial}, 8'h01);
    rst = 1'b1;
    @(negedge clk80);
    chk("orb_drop_on_rst", {7'h0, Orb_serial}, 8'h00);
    repeat (9) @(negedge clk80);
    rst = 1'b0;
    for (int j = 1; j < 17; j++) begin
      get_byte(j, v);
      chk($sformatf("ch0_after_rst_byte_%0d", j), v, 8'h00);
    end
    wait_cyc(3420);
    send(15, 0, 7, 17);
    ns = '{15, 0, 7, 17};
    for (int j = 0; j < 65; j++) begin
      get_byte(65 + j, v);
      chk($sformatf("mixed_frame_byte_%0d", j), v, exp_byte(j));
    end
    get_byte(178, v);
    chk("ch2_status_after_req", v, 8'h00);
    get_byte(179, v);
    chk("ch3_buf0_after_req", v, 8'h55);
    get_byte(194, v);
    chk("ch3_status_after_req", v, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
